// File: rtl/upsizer_module_if.sv
// Narrow input stream and wide output stream of the upsizer, bundled as one port.
// slave is the upsizer's view; master is the producer/consumer side.
interface upsizer_module_if #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_DATA_RATIO = 2
);
    logic [T_DATA_WIDTH-1:0]                   s_data_i;
    logic                                      s_last_i;
    logic                                      s_valid_i;
    logic                                      s_ready_o;
    logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] m_data_0;
    logic [T_DATA_RATIO-1:0]                   m_keep_o;
    logic                                      m_last_o;
    logic                                      m_valid_o;
    logic                                      m_ready_i;

    modport slave (
        input  s_data_i, s_last_i, s_valid_i, m_ready_i,
        output s_ready_o, m_data_0, m_keep_o, m_last_o, m_valid_o
    );

    modport master (
        output s_data_i, s_last_i, s_valid_i, m_ready_i,
        input  s_ready_o, m_data_0, m_keep_o, m_last_o, m_valid_o
    );
endinterface

// File: rtl/upsizer_module.sv
// Stream width upsizer: packs T_DATA_RATIO narrow beats into one wide word,
// flushing a partial word early on packet last.
module upsizer_lane #(
    parameter int T_DATA_WIDTH = 4,
    parameter int CW           = 1,
    parameter int IDX          = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CW-1:0]           cnt,
    input  logic [T_DATA_WIDTH-1:0] din,
    input  logic                    store,
    input  logic                    load,
    output logic [T_DATA_WIDTH-1:0] dout,
    output logic                    keep
);
    logic [T_DATA_WIDTH-1:0] acc;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            acc  <= '0;
            dout <= '0;
            keep <= 1'b0;
        end else begin
            if (store && cnt == CW'(IDX))
                acc <= din;
            // Lanes below the completing beat come from the accumulator, lanes above are zeroed.
            if (load) begin
                if (CW'(IDX) < cnt)       dout <= acc;
                else if (CW'(IDX) == cnt) dout <= din;
                else                      dout <= '0;
                keep <= (CW'(IDX) <= cnt);
            end
        end
    end
endmodule

module upsizer_module #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_DATA_RATIO = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    upsizer_module_if.slave     bus
);
    localparam int CW = $clog2(T_DATA_RATIO);

    logic [CW-1:0]                             cnt;
    logic                                      valid_q;
    logic                                      last_q;
    logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] data_q;
    logic [T_DATA_RATIO-1:0]                   keep_q;
    logic                                      accept;
    logic                                      complete;

    assign bus.s_ready_o = !rst_n && (!valid_q || bus.m_ready_i);
    assign accept        = bus.s_valid_i && bus.s_ready_o;
    assign complete      = accept && (cnt == CW'(T_DATA_RATIO-1) || bus.s_last_i);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (complete) begin
            // Reload covers the consume-and-complete case with no bubble.
            cnt     <= '0;
            valid_q <= 1'b1;
            last_q  <= bus.s_last_i;
        end else begin
            if (accept)        cnt     <= cnt + 1'b1;
            if (bus.m_ready_i) valid_q <= 1'b0;
        end
    end

    for (genvar i = 0; i < T_DATA_RATIO; i++) begin : g_lane
        upsizer_lane #(
            .T_DATA_WIDTH(T_DATA_WIDTH),
            .CW          (CW),
            .IDX         (i)
        ) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .cnt  (cnt),
            .din  (bus.s_data_i),
            .store(accept && !complete && (i < T_DATA_RATIO-1)),
            .load (complete),
            .dout (data_q[i]),
            .keep (keep_q[i])
        );
    end

    assign bus.m_data_0  = data_q;
    assign bus.m_keep_o  = keep_q;
    assign bus.m_last_o  = last_q;
    assign bus.m_valid_o = valid_q;
endmodule

// File: tb/tb_upsizer_module.sv
// Randomized and directed checks of upsizer_module against a beat-list packing model.
module tb_upsizer_module;
    localparam int W = 4;
    localparam int R = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    upsizer_module_if #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) bus ();

    upsizer_module #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: beats gathered for the word in progress, and the word being presented.
    logic [W-1:0]          beats[$];
    bit                    exp_valid;
    logic [R-1:0][W-1:0]   exp_data;
    logic [R-1:0]          exp_keep;
    logic                  exp_last;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        beats.delete();
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_keep  = '0;
        exp_last  = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b1;
        bus.s_valid_i = 1'b0;
        bus.m_ready_i = 1'b0;
        model_clear();
        repeat (n) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rst_ready", 64'(bus.s_ready_o), 64'd0);
            chk("rst_valid", 64'(bus.m_valid_o), 64'd0);
            chk("rst_keep",  64'(bus.m_keep_o),  64'd0);
            chk("rst_last",  64'(bus.m_last_o),  64'd0);
            chk("rst_data",  64'(bus.m_data_0),  64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
    endtask

    task automatic cycle(input bit v, input logic [W-1:0] d, input bit l, input bit mr);
        bit take, consume;
        bus.s_valid_i = v;
        bus.s_data_i  = d;
        bus.s_last_i  = l;
        bus.m_ready_i = mr;
        @(negedge clk);
        chk("s_ready", 64'(bus.s_ready_o), 64'(!exp_valid || mr));
        chk("m_valid", 64'(bus.m_valid_o), 64'(exp_valid));
        if (exp_valid) begin
            chk("m_data", 64'(bus.m_data_0), 64'(exp_data));
            chk("m_keep", 64'(bus.m_keep_o), 64'(exp_keep));
            chk("m_last", 64'(bus.m_last_o), 64'(exp_last));
        end
        consume = exp_valid && mr;
        take    = v && (!exp_valid || mr);
        if (take) beats.push_back(d);
        if (take && (beats.size() == R || l)) begin
            exp_data = '0;
            foreach (beats[i]) exp_data[i] = beats[i];
            exp_keep  = R'((1 << beats.size()) - 1);
            exp_last  = l;
            exp_valid = 1'b1;
            beats.delete();
        end else if (consume) begin
            exp_valid = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = '0;
        bus.s_last_i  = 1'b0;
        bus.m_ready_i = 1'b0;
        model_clear();

        do_reset(2);

        // Full words
        cycle(1, 4'd1, 0, 1); cycle(1, 4'd2, 0, 1);
        cycle(1, 4'd3, 0, 1); cycle(1, 4'd4, 0, 1);
        cycle(0, 4'd0, 0, 1);
        // Short packet, then next beat starts lane 0
        cycle(1, 4'd5, 1, 1); cycle(1, 4'd6, 0, 1); cycle(1, 4'd9, 1, 1);
        // Last on a full word
        cycle(1, 4'd7, 0, 1); cycle(1, 4'd8, 1, 1);
        cycle(0, 4'd0, 0, 1);
        // Backpressure: word held, offered beat not taken
        cycle(1, 4'd1, 0, 1); cycle(1, 4'd2, 0, 0);
        repeat (4) cycle(1, 4'd3, 0, 0);
        cycle(0, 4'd0, 0, 1); cycle(0, 4'd0, 0, 1);
        // Gapped input with garbage on idle beats
        cycle(1, 4'd1, 0, 1); cycle(0, 4'hF, 1, 1);
        cycle(1, 4'd2, 0, 1); cycle(0, 4'hE, 1, 1);
        cycle(1, 4'd3, 0, 1); cycle(0, 4'hD, 1, 1);
        cycle(1, 4'd4, 0, 1); cycle(0, 4'hC, 1, 1);
        cycle(0, 4'd0, 0, 1);

        // Reset mid-word and mid-output
        cycle(1, 4'd7, 0, 1);
        do_reset(2);
        cycle(1, 4'd3, 0, 1); cycle(1, 4'd5, 0, 0);
        do_reset(1);
        cycle(1, 4'd2, 1, 1); cycle(0, 4'd0, 0, 1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 3) != 0), W'($urandom),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 7));
        end
        repeat (3) cycle(0, 4'd0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/upsizer_module.md
# upsizer_module

Stream width upsizer: packs T_DATA_RATIO consecutive narrow input beats of T_DATA_WIDTH bits into one wide output word of T_DATA_RATIO lanes, with per-lane keep and packet-last. It sits between a narrow valid/ready stream producer and a wide consumer. A packet end (s_last_i) flushes a partially filled word early.

## Interface
- T_DATA_WIDTH, default 4: bits per input beat and per output lane.
- T_DATA_RATIO, default 2: input beats per output word (≥2).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset: synchronous, active-high (name kept per codebase).
- s_data_i  input  T_DATA_WIDTH  input beat data.
- s_last_i  input  1  input beat is the last of its packet.
- s_valid_i  input  1  input beat valid.
- s_ready_o  output  1  block can accept an input beat.
- m_data_0  output  array [T_DATA_RATIO-1:0] of T_DATA_WIDTH  output lanes; lane 0 holds the first beat.
- m_keep_o  output  T_DATA_RATIO  bit i set = lane i holds valid data.
- m_last_o  output  1  output word contains the packet's last beat.
- m_valid_o  output  1  output word valid.
- m_ready_i  input  1  consumer accepts output word.

## Operation
- Input handshake: beat accepted when s_valid_i && s_ready_o at rising edge. Output handshake: word consumed when m_valid_o && m_ready_i.
- Internal state: accumulator of T_DATA_RATIO-1 lanes, lane counter cnt (0..T_DATA_RATIO-1), output register (data, keep, last, valid).
- s_ready_o = !rst_n-asserted && (!m_valid_o || m_ready_i); combinational.
- Accepted beat with cnt < T_DATA_RATIO-1 and s_last_i=0: stored in accumulator lane cnt; cnt increments.
- Accepted beat with cnt == T_DATA_RATIO-1 or s_last_i=1 (completing beat): output register loads lanes 0..cnt-1 from accumulator, lane cnt from s_data_i, lanes above cnt forced to zero; m_keep_o = lowest cnt+1 bits set; m_last_o = s_last_i; m_valid_o=1; cnt returns to 0.
- s_last_i on the first beat of a word produces a word with keep = 1 (lane 0 only).
- Output register holds data/keep/last stable while m_valid_o && !m_ready_i.
- Consumed with no new completing beat in the same cycle: m_valid_o clears next edge; data/keep/last hold last value.
- Consume and new completing beat in same cycle: output register reloads; m_valid_o stays 1 (no bubble).
- s_data_i/s_last_i ignored when s_valid_i=0 or s_ready_o=0.

## Timing
- Reset (rst_n=1 at an edge): m_valid_o=0, m_last_o=0, m_keep_o=0, all m_data_0 lanes=0, cnt=0, accumulator=0; s_ready_o=0 while reset is asserted.
- First edge after reset release: s_ready_o=1.
- Latency: completing beat accepted at edge N -> m_valid_o=1 after edge N.
- Throughput: with m_ready_i held 1, one input beat per cycle; one output word per T_DATA_RATIO cycles (fewer on short packets).
- Backpressure: while m_valid_o=1 and m_ready_i=0, s_ready_o=0; accumulator and cnt hold.
- Reset mid-word or mid-output: partial accumulator and pending output discarded.

## Test plan
- Reset: assert rst_n 2 cycles -> m_valid_o=0, m_keep_o=00, m_last_o=0, lanes 0, s_ready_o=0; release -> s_ready_o=1.
- Full words (W=4,R=2), m_ready_i=1: beats 1,2,3,4, s_last_i=0 -> words {lane0=1,lane1=2} then {3,4}, keep=11, last=0, each valid one cycle after 2nd beat.
- Short packet: beat 5 with s_last_i=1 at cnt=0 -> word lane0=5, lane1=0, keep=01, last=1; next beat 6 lands in lane 0.
- Last on full word: beats 7, 8(s_last_i=1) -> lanes {7,8}, keep=11, last=1.
- Backpressure: hold m_ready_i=0 while word {1,2} valid -> word stable, s_ready_o=0 for all stalled cycles; release -> consumed, s_ready_o=1 same cycle.
- Gapped input: s_valid_i toggling 1/0 with data 1,2,3,4 -> words {1,2},{3,4}; idle beats not captured.
